// File: rtl/sseg_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed, active-low seven-segment scan.
// Each digit must dwell unchanged for STABLE_CYCLES samples before capture; a frame completes once all four digits are seen.
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  sseg,
    input  logic [3:0]  an,
    output logic [15:0] outnum,
    output logic        valid,
    output logic        err
);

    typedef enum logic [1:0] {S_WAIT, S_DWELL, S_HELD} state_t;

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    function automatic logic an_is_valid(input logic [3:0] a);
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_is_valid = 1'b1;
            default:                            an_is_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] a);
        case (a)
            4'b1101: digit_index = 2'd1;
            4'b1011: digit_index = 2'd2;
            4'b0111: digit_index = 2'd3;
            default: digit_index = 2'd0;
        endcase
    endfunction

    // Returns {decodable, code}; segments a..g, 0 = lit.
    function automatic logic [4:0] seg_decode(input logic [0:6] s);
        case (s)
            7'b0000001: seg_decode = {1'b1, 4'h0};
            7'b1001111: seg_decode = {1'b1, 4'h1};
            7'b0010010: seg_decode = {1'b1, 4'h2};
            7'b0000110: seg_decode = {1'b1, 4'h3};
            7'b1001100: seg_decode = {1'b1, 4'h4};
            7'b0100100: seg_decode = {1'b1, 4'h5};
            7'b0100000: seg_decode = {1'b1, 4'h6};
            7'b0001111: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0000100: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b1100000: seg_decode = {1'b1, 4'hB};
            7'b0110001: seg_decode = {1'b1, 4'hC};
            7'b1000010: seg_decode = {1'b1, 4'hD};
            7'b0110000: seg_decode = {1'b1, 4'hE};
            7'b0111000: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [1:0]  run_q;
    logic        run;
    state_t      state_q;
    logic [3:0]  an_q;
    logic [0:6]  sseg_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] outnum_q;
    logic        valid_q, err_q;

    logic        an_ok, same, capture, dec_ok;
    logic [3:0]  dec_code;
    logic [1:0]  idx;

    // Reset asserts asynchronously but releases through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 2'b00;
        else      run_q <= {run_q[0], 1'b1};
    end
    assign run = run_q[1];

    always_comb begin
        an_ok              = an_is_valid(an);
        same               = (an == an_q) && (sseg == sseg_q);
        cnt_d              = 8'd0;
        if (same && an_ok)
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        capture            = (state_q == S_DWELL) && same && an_ok && (cnt_d == CAP_CNT);
        {dec_ok, dec_code} = seg_decode(sseg);
        idx                = digit_index(an);
        shadow_d           = shadow_q;
        shadow_d[{idx, 2'b00} +: 4] = dec_code;
        seen_d             = seen_q | (4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_WAIT;
            an_q     <= 4'b1111;
            sseg_q   <= 7'b1111111;
            cnt_q    <= 8'd0;
            seen_q   <= 4'b0000;
            shadow_q <= 16'h0000;
            outnum_q <= 16'h0000;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (run) begin
            an_q    <= an;
            sseg_q  <= sseg;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!an_ok) begin
                state_q <= S_WAIT;
            end else begin
                case (state_q)
                    S_WAIT: state_q <= S_DWELL;
                    S_DWELL: begin
                        if (capture) begin
                            state_q <= S_HELD;
                            if (dec_ok) begin
                                shadow_q <= shadow_d;
                                if (seen_d == 4'b1111) begin
                                    outnum_q <= shadow_d;
                                    valid_q  <= 1'b1;
                                    seen_q   <= 4'b0000;
                                end else begin
                                    seen_q <= seen_d;
                                end
                            end else begin
                                // Undecodable pattern aborts the partial frame.
                                err_q  <= 1'b1;
                                seen_q <= 4'b0000;
                            end
                        end
                    end
                    S_HELD: if (!same) state_q <= S_DWELL;
                    default: state_q <= S_WAIT;
                endcase
            end
        end
    end

    assign outnum = outnum_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: clean scans, glitches, undecodable digits,
// short dwell, mid-frame reset and a continuous hex scan of 16'h10E1.
module tb_sseg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [0:6]  sseg;
    logic [3:0]  an;
    logic [15:0] outnum;
    logic        valid;
    logic        err;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int ecnt  = 0;
    int both  = 0;
    int v0, e0;

    sseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .sseg   (sseg),
        .an     (an),
        .outnum (outnum),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (err) ecnt++;
        if (valid && err) both++;
    end

    function automatic logic [0:6] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [0:6] s);
        @(negedge clk);
        an   = a;
        sseg = s;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(4'b1111, 7'b1111111);
    endtask

    task automatic dig(input int d, input logic [3:0] n, input int dwell);
        for (int i = 0; i < dwell; i++) step(an_of(d), enc(n));
    endtask

    task automatic scan(input logic [15:0] v, input int dwell);
        for (int d = 0; d < 4; d++) begin
            dig(d, v[d*4 +: 4], dwell);
            gap(1);
        end
    endtask

    initial begin
        rst  = 1'b0;
        an   = 4'b1111;
        sseg = 7'b1111111;
        #5;
        chk("rst_outnum", 32'(outnum), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        #5 rst = 1'b1;
        gap(4);
        chk("idle_outnum", 32'(outnum), 32'h0);
        chk("idle_vcnt", 32'(vcnt), 32'h0);

        // Clean 4321 scan with latency check on the final digit.
        dig(0, 4'h1, 8); gap(1);
        dig(1, 4'h2, 8); gap(1);
        dig(2, 4'h3, 8); gap(1);
        for (int i = 0; i < 4; i++) step(4'b0111, enc(4'h4));
        chk("lat_pre_valid", 32'(valid), 32'h0);
        step(4'b0111, enc(4'h4));
        chk("lat_valid", 32'(valid), 32'h1);
        chk("lat_outnum", 32'(outnum), 32'h4321);
        for (int i = 0; i < 3; i++) step(4'b0111, enc(4'h4));
        gap(2);
        chk("clean_vcnt", 32'(vcnt), 32'd1);
        chk("clean_ecnt", 32'(ecnt), 32'd0);

        // Glitch after capture in the an[2] dwell.
        v0 = vcnt; e0 = ecnt;
        dig(0, 4'h1, 8); gap(1);
        dig(1, 4'h2, 8); gap(1);
        for (int i = 0; i < 4; i++) step(4'b1011, enc(4'h3));
        for (int i = 0; i < 2; i++) step(4'b1011, 7'b0000000);
        for (int i = 0; i < 2; i++) step(4'b1011, enc(4'h3));
        gap(1);
        dig(3, 4'h4, 8); gap(2);
        chk("glitch_vdelta", 32'(vcnt - v0), 32'd1);
        chk("glitch_edelta", 32'(ecnt - e0), 32'd0);
        chk("glitch_outnum", 32'(outnum), 32'h4321);

        // Blank digit on an[1], then clean A0F9.
        v0 = vcnt; e0 = ecnt;
        for (int i = 0; i < 8; i++) step(4'b1101, 7'b1111111);
        gap(2);
        chk("blank_edelta", 32'(ecnt - e0), 32'd1);
        chk("blank_vdelta", 32'(vcnt - v0), 32'd0);
        chk("blank_outnum", 32'(outnum), 32'h4321);
        v0 = vcnt; e0 = ecnt;
        scan(16'hA0F9, 8); gap(1);
        chk("a0f9_vdelta", 32'(vcnt - v0), 32'd1);
        chk("a0f9_outnum", 32'(outnum), 32'hA0F9);

        // Undecodable digit aborts a partial frame.
        v0 = vcnt; e0 = ecnt;
        dig(0, 4'h1, 8); gap(1);
        dig(1, 4'h2, 8); gap(1);
        dig(2, 4'h3, 8); gap(1);
        for (int i = 0; i < 8; i++) step(4'b0111, 7'b1111111);
        gap(2);
        chk("abort_edelta", 32'(ecnt - e0), 32'd1);
        chk("abort_vdelta", 32'(vcnt - v0), 32'd0);
        chk("abort_outnum", 32'(outnum), 32'hA0F9);
        dig(3, 4'h4, 8); gap(2);
        chk("lone_vdelta", 32'(vcnt - v0), 32'd0);
        dig(0, 4'h8, 8); gap(1);
        dig(1, 4'h7, 8); gap(1);
        dig(2, 4'h6, 8); gap(2);
        chk("order_vdelta", 32'(vcnt - v0), 32'd1);
        chk("order_outnum", 32'(outnum), 32'h4678);

        // Short dwell never captures.
        v0 = vcnt;
        scan(16'h5678, 3); gap(2);
        chk("short_vdelta", 32'(vcnt - v0), 32'd0);
        chk("short_outnum", 32'(outnum), 32'h4678);

        // Reset mid-frame.
        v0 = vcnt;
        dig(0, 4'h1, 8); gap(1);
        dig(1, 4'h2, 8); gap(1);
        dig(2, 4'h3, 8); gap(1);
        chk("partial_vdelta", 32'(vcnt - v0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_outnum", 32'(outnum), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        #3 rst = 1'b1;
        gap(3);
        v0 = vcnt;
        dig(3, 4'h4, 8); gap(2);
        chk("postrst_vdelta", 32'(vcnt - v0), 32'd0);
        chk("postrst_outnum", 32'(outnum), 32'h0);
        scan(16'h4321, 8); gap(1);
        chk("rescan_vdelta", 32'(vcnt - v0), 32'd1);
        chk("rescan_outnum", 32'(outnum), 32'h4321);

        // Continuous scan of 4321 decimal as hex digits.
        v0 = vcnt; e0 = ecnt;
        scan(16'h10E1, 8);
        scan(16'h10E1, 8);
        gap(2);
        chk("loop_vdelta", 32'(vcnt - v0), 32'd2);
        chk("loop_outnum", 32'(outnum), 32'h10E1);
        chk("loop_edelta", 32'(ecnt - e0), 32'd0);
        chk("valid_err_both", 32'(both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
